// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-lite master: turns one core load/store request into
// one AXI4-lite write (AW+W+B) or read (AR+R) transaction and returns its status.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [2:0]            AWPROT,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [2:0]            ARPROT,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] WRITE_B = 3'd2;
  localparam logic [2:0] READ_A  = 3'd3;
  localparam logic [2:0] READ_R  = 3'd4;

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]            state_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_error_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic                  awvalid_r;
  logic                  wvalid_r;
  logic                  bready_r;
  logic                  arvalid_r;
  logic                  rready_r;
  logic [CNT_W-1:0]      cnt_r;

  logic                  timeout_s;
  logic [CNT_W-1:0]      cnt_next_s;
  logic                  aw_done_s;
  logic                  w_done_s;

  // Response-wait timeout detection and saturating counter increment.
  always_comb begin
    timeout_s  = 1'b0;
    cnt_next_s = cnt_r;
    if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if (cnt_r != CNT_MAX) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // A channel counts as done if it already handshook or is handshaking now.
  assign aw_done_s = !awvalid_r || AWREADY;
  assign w_done_s  = !wvalid_r || WREADY;

  // Transaction FSM with all handshake and response outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_error_r <= 1'b0;
      rsp_rdata_r <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      cnt_r       <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            wstrb_r     <= req_wstrb;
            req_ready_r <= 1'b0;
            if (req_write) begin
              state_r   <= WRITE;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              state_r   <= READ_A;
              arvalid_r <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (AWREADY) awvalid_r <= 1'b0;
          if (WREADY)  wvalid_r  <= 1'b0;
          if (aw_done_s && w_done_s) begin
            state_r  <= WRITE_B;
            bready_r <= 1'b1;
            cnt_r    <= '0;
          end
        end
        WRITE_B: begin
          if (BVALID) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= (BRESP != 2'b00);
          end else if (timeout_s) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= 1'b1;
            rsp_rdata_r <= '0;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        READ_A: begin
          if (ARREADY) begin
            state_r   <= READ_R;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            cnt_r     <= '0;
          end
        end
        READ_R: begin
          if (RVALID) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= (RRESP != 2'b00);
            rsp_rdata_r <= RDATA;
          end else if (timeout_s) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= 1'b1;
            rsp_rdata_r <= '0;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_error = rsp_error_r;
  assign rsp_rdata = rsp_rdata_r;
  assign AWVALID   = awvalid_r;
  assign AWADDR    = addr_r;
  assign AWPROT    = 3'b000;
  assign WVALID    = wvalid_r;
  assign WDATA     = wdata_r;
  assign WSTRB     = wstrb_r;
  assign BREADY    = bready_r;
  assign ARVALID   = arvalid_r;
  assign ARADDR    = addr_r;
  assign ARPROT    = 3'b000;
  assign RREADY    = rready_r;

endmodule
